// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake status, bus word and the memory arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    IFETCH,
    DREAD,
    DWRITE,
    SCFAIL
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Datapath-side request/response signals and the shared RAM port seen by the memory arbiter.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  logic      dREN;
  logic      dWEN;
  logic      datomic;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      err;

  // master: the arbiter itself; slave: the requesters and RAM around it
  modport master (
    input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/link_register.sv
// LL/SC reservation: a valid bit plus the linked word address, with an address-match compare.
module link_register
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  set,
  input  logic  clr,
  input  word_t set_addr,
  input  word_t cmp_addr,
  output logic  match
);

  logic  valid;
  word_t addr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (set) begin
      valid <= 1'b1;
      addr  <= set_addr;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

  assign match = valid && (addr == cmp_addr);

endmodule

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data access, with LL/SC link tracking
// and a bounded retry on RAM ERROR responses.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter bit FAIR      = 1'b1,
  parameter int RETRY_MAX = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  memory_arbiter_if.master bus
);

  localparam int                RW         = $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0]     RETRY_LAST = RW'(RETRY_MAX - 1);

  arb_state_t    state, next_state;
  logic          last_d;
  logic [RW-1:0] retry;
  logic          link_match;
  logic          d_req, grant_d, forced, done, strobing;
  logic          link_set, link_clr;

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    d_req      = bus.dREN | bus.dWEN;
    grant_d    = d_req && (!FAIR || !bus.iREN || !last_d);
    strobing   = (state == IFETCH) || (state == DREAD) || (state == DWRITE);
    forced     = (bus.ramstate == ERROR) && (retry == RETRY_LAST);
    done       = strobing && ((bus.ramstate == ACCESS) || forced);

    next_state   = state;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = bus.iREN;
    bus.dwait    = d_req;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.err      = 1'b0;

    case (state)
      IDLE: begin
        if (grant_d) begin
          if (bus.dWEN) next_state = (bus.datomic && !link_match) ? SCFAIL : DWRITE;
          else          next_state = DREAD;
        end else if (bus.iREN) begin
          next_state = IFETCH;
        end
      end
      IFETCH: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        if (done) begin
          bus.iwait  = 1'b0;
          bus.iload  = forced ? '0 : bus.ramload;
          bus.err    = forced;
          next_state = IDLE;
        end
      end
      DREAD: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.daddr;
        if (done) begin
          bus.dwait  = 1'b0;
          bus.dload  = forced ? '0 : bus.ramload;
          bus.err    = forced;
          next_state = IDLE;
        end
      end
      DWRITE: begin
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (done) begin
          // an atomic write only reaches DWRITE when its link matched, so it reports success
          bus.dwait  = 1'b0;
          bus.dload  = forced ? '0 : (bus.datomic ? 32'd1 : bus.ramload);
          bus.err    = forced;
          next_state = IDLE;
        end
      end
      SCFAIL: begin
        bus.dwait  = 1'b0;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      last_d <= 1'b0;
      retry  <= '0;
    end else if (done) begin
      last_d <= (state != IFETCH);
      retry  <= '0;
    end else if (strobing && (bus.ramstate == ERROR)) begin
      retry  <= retry + 1'b1;
    end else if (state == SCFAIL) begin
      last_d <= 1'b1;
    end
  end

  assign link_set = done && (state == DREAD) && bus.datomic;
  assign link_clr = (done && (state == DWRITE) && link_match) || (state == SCFAIL);

  link_register u_link (
    .clk      (CLK),
    .rst      (nRST),
    .set      (link_set),
    .clr      (link_clr),
    .set_addr (bus.daddr),
    .cmp_addr (bus.daddr),
    .match    (link_match)
  );

endmodule

// File: tb/tb_memory_arbiter.sv
// Random and directed transactions against a RAM responder, checked by a word-level
// memory/link reference model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int RETRY_MAX = 4;

  typedef enum int {K_IF, K_RD, K_WR, K_LL, K_SC} kind_t;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  memory_arbiter_if bus ();
  memory_arbiter_if bus0 ();

  memory_arbiter #(.FAIR(1'b1), .RETRY_MAX(RETRY_MAX)) dut (
    .CLK (CLK), .nRST (nRST), .bus (bus.master)
  );

  memory_arbiter #(.FAIR(1'b0), .RETRY_MAX(RETRY_MAX)) dut0 (
    .CLK (CLK), .nRST (nRST), .bus (bus0.master)
  );

  assign bus0.ramstate = (bus0.ramREN || bus0.ramWEN) ? ACCESS : FREE;
  assign bus0.ramload  = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;

  word_t     ram     [word_t];
  word_t     ref_mem [word_t];
  bit        ref_link_v = 1'b0;
  word_t     ref_link_a = '0;
  ramstate_t plan_q[$];

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic word_t rd_ram(input word_t a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  function automatic word_t rd_ref(input word_t a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // RAM responder: answers each strobe cycle from the planned status list, ACCESS when empty
  always @(negedge CLK) begin
    ramstate_t rs;
    if (bus.ramREN || bus.ramWEN) begin
      rs = (plan_q.size() > 0) ? plan_q.pop_front() : ACCESS;
      bus.ramstate = rs;
      bus.ramload  = (rs == ACCESS && bus.ramREN) ? rd_ram(bus.ramaddr) : $urandom;
    end else begin
      bus.ramstate = FREE;
      bus.ramload  = $urandom;
    end
  end

  always @(posedge CLK) begin
    if (!nRST && bus.ramWEN && bus.ramstate == ACCESS) ram[bus.ramaddr] = bus.ramstore;
  end

  // One request from a single side. Latency counts strobe/result cycles after the
  // arbitration cycle, so the minimum "2-cycle" access shows up as 1 here.
  task automatic txn(input kind_t k, input word_t addr, input word_t wdata,
                     input int n_err, input int n_busy);
    ramstate_t plan[$];
    int    lat_exp, cyc, errs, errs_seen, bad;
    bit    forced, sc_ok, is_wr, is_d, done;
    word_t got, exp_v;

    for (int i = 0; i < n_err; i++) plan.push_back(ERROR);
    for (int i = 0; i < n_busy; i++) plan.insert($urandom_range(plan.size()), BUSY);
    plan.push_back(ACCESS);

    is_d   = (k != K_IF);
    is_wr  = (k == K_WR) || (k == K_SC);
    sc_ok  = ref_link_v && (ref_link_a == addr);
    forced = 1'b0;
    errs   = 0;
    lat_exp = 0;
    if (k == K_SC && !sc_ok) begin
      lat_exp = 1;
    end else begin
      foreach (plan[i]) begin
        if (lat_exp == 0) begin
          if (plan[i] == ERROR) errs++;
          if (plan[i] == ACCESS || errs == RETRY_MAX) begin
            lat_exp = i + 1;
            forced  = (plan[i] == ERROR);
          end
        end
      end
    end

    @(negedge CLK);
    plan_q      = plan;
    bus.iREN    = (k == K_IF);
    bus.iaddr   = addr;
    bus.dREN    = (k == K_RD) || (k == K_LL);
    bus.dWEN    = is_wr;
    bus.datomic = (k == K_LL) || (k == K_SC);
    bus.daddr   = addr;
    bus.dstore  = wdata;

    cyc = 0; errs_seen = 0; bad = 0; done = 1'b0; got = '0;
    while (!done && cyc < 64) begin
      @(negedge CLK);
      #1;
      cyc++;
      errs_seen += int'(bus.err);
      if (k == K_SC && !sc_ok)
        bad += int'(bus.ramREN | bus.ramWEN);
      else
        bad += int'((bus.ramREN != !is_wr) || (bus.ramWEN != is_wr) ||
                    (bus.ramaddr != addr) || (is_wr && bus.ramstore != wdata));
      done = is_d ? !bus.dwait : !bus.iwait;
      if (done) got = is_d ? bus.dload : bus.iload;
    end

    check({k.name(), "_done"},   word_t'(done), 32'd1);
    check({k.name(), "_lat"},    word_t'(cyc), word_t'(lat_exp));
    check({k.name(), "_err"},    word_t'(errs_seen), word_t'(forced));
    check({k.name(), "_strobe"}, word_t'(bad), 32'd0);
    if (k != K_WR) begin
      if (forced)        exp_v = 32'h0;
      else if (k == K_SC) exp_v = sc_ok ? 32'd1 : 32'd0;
      else               exp_v = rd_ref(addr);
      check({k.name(), "_data"}, got, exp_v);
    end

    @(posedge CLK);
    #1;
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.datomic = 1'b0;

    if (k == K_WR || (k == K_SC && sc_ok)) begin
      if (!forced) ref_mem[addr] = wdata;
      if (ref_link_v && ref_link_a == addr) ref_link_v = 1'b0;
    end
    if (k == K_SC) ref_link_v = 1'b0;
    if (k == K_LL) begin
      ref_link_v = 1'b1;
      ref_link_a = addr;
    end
  endtask

  initial begin
    int    gq[$], gq0[$];
    bit    fair_exp[4];
    word_t pool[4];
    kind_t k;

    fair_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    pool     = '{32'h100, 32'h104, 32'h200, 32'h40};

    bus.iREN = 1'b1; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.datomic = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus0.iREN = 1'b0; bus0.iaddr = '0; bus0.dREN = 1'b0; bus0.dWEN = 1'b0;
    bus0.datomic = 1'b0; bus0.daddr = '0; bus0.dstore = '0;
    ram[32'h40]     = 32'h8C01_0004;
    ref_mem[32'h40] = 32'h8C01_0004;

    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_ramREN", word_t'(bus.ramREN), 32'd0);
    check("rst_ramWEN", word_t'(bus.ramWEN), 32'd0);
    check("rst_err",    word_t'(bus.err),    32'd0);
    check("rst_iload",  bus.iload,           32'd0);
    check("rst_dload",  bus.dload,           32'd0);
    check("rst_iwait",  word_t'(bus.iwait),  32'd1);
    check("rst_dwait",  word_t'(bus.dwait),  32'd0);
    bus.iREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b0;

    // both sides pending continuously: FAIR alternates from D, FAIR=0 always picks D
    @(negedge CLK);
    bus.iREN = 1'b1;  bus.iaddr = 32'h40;  bus.dREN = 1'b1;  bus.daddr = 32'h200;
    bus0.iREN = 1'b1; bus0.iaddr = 32'h40; bus0.dREN = 1'b1; bus0.daddr = 32'h200;
    for (int c = 0; c < 40 && (gq.size() < 4 || gq0.size() < 4); c++) begin
      @(negedge CLK);
      #1;
      if (bus.ramREN && bus.ramstate == ACCESS) gq.push_back(int'(bus.ramaddr == 32'h200));
      if (bus0.ramREN)                          gq0.push_back(int'(bus0.ramaddr == 32'h200));
    end
    for (int i = 0; i < 4; i++) begin
      check("fair_grant",   word_t'(gq.size() > i ? gq[i] : 2),   word_t'(fair_exp[i]));
      check("nofair_grant", word_t'(gq0.size() > i ? gq0[i] : 2), 32'd1);
    end
    bus.iREN = 1'b0;  bus.dREN = 1'b0;
    bus0.iREN = 1'b0; bus0.dREN = 1'b0;
    repeat (2) @(negedge CLK);

    txn(K_IF, 32'h40, 32'h0, 0, 0);

    txn(K_LL, 32'h100, 32'h0, 0, 0);
    txn(K_SC, 32'h100, 32'h7, 0, 0);
    txn(K_SC, 32'h100, 32'h9, 0, 0);

    txn(K_LL, 32'h100, 32'h0,  0, 0);
    txn(K_WR, 32'h100, 32'h55, 0, 0);
    txn(K_SC, 32'h100, 32'h77, 0, 0);
    txn(K_RD, 32'h100, 32'h0,  0, 0);

    txn(K_RD, 32'h104, 32'h0, RETRY_MAX, 0);
    txn(K_RD, 32'h104, 32'h0, RETRY_MAX - 1, 1);

    // reset in the middle of a stalled write drops the strobe and the reservation
    txn(K_LL, 32'h100, 32'h0, 0, 0);
    @(negedge CLK);
    plan_q.delete();
    repeat (20) plan_q.push_back(BUSY);
    bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'hDEAD;
    repeat (3) @(negedge CLK);
    #1;
    check("pre_rst_ramWEN", word_t'(bus.ramWEN), 32'd1);
    nRST = 1'b1;
    #1;
    check("mid_rst_ramWEN", word_t'(bus.ramWEN), 32'd0);
    check("mid_rst_dwait",  word_t'(bus.dwait),  32'd1);
    bus.dWEN = 1'b0;
    @(negedge CLK);
    nRST = 1'b0;
    plan_q.delete();
    ref_link_v = 1'b0;
    txn(K_SC, 32'h100, 32'h11, 0, 0);

    for (int t = 0; t < 120; t++) begin
      k = kind_t'($urandom_range(4));
      txn(k, pool[$urandom_range(3)], $urandom,
          ($urandom_range(5) == 0) ? int'($urandom_range(5, 1)) : 0,
          int'($urandom_range(2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
